// File: rtl/bar_placer.sv
// Cursor-driven editor that commits up to four obstacle bars, then freezes them for play.
// Optional macro BAR_OVERLAP_CHECK_EN rejects placements whose 2 px grown box touches a committed bar.
module bar_placer #(
    parameter int BAR_LEN   = 10,
    parameter int STEP      = 1,
    parameter int X_MIN     = 2,
    parameter int X_MAX     = 112,
    parameter int Y_MIN     = 4,
    parameter int Y_MAX     = 115,
    parameter int CURSOR_X0 = 60,
    parameter int CURSOR_Y0 = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_rotate,
    input  logic        btn_place,
    input  logic        btn_done,
    output logic [15:0] bar1,
    output logic [15:0] bar2,
    output logic [15:0] bar3,
    output logic [15:0] bar4,
    output logic [3:0]  bar_valid,
    output logic [7:0]  cursor_x,
    output logic [6:0]  cursor_y,
    output logic        cursor_vert,
    output logic [2:0]  slot,
    output logic        locked,
    output logic        place_err
);

    typedef enum logic [1:0] {IDLE, EDIT, LOCKED} state_t;

    localparam logic [8:0] XLO   = 9'(X_MIN);
    localparam logic [8:0] XHI_V = 9'(X_MAX);
    localparam logic [8:0] XHI_H = 9'(X_MAX - BAR_LEN + 1);
    localparam logic [8:0] YLO   = 9'(Y_MIN);
    localparam logic [8:0] YHI_V = 9'(Y_MAX - BAR_LEN + 1);
    localparam logic [8:0] YHI_H = 9'(Y_MAX);
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [7:0] X0    = 8'(CURSOR_X0);
    localparam logic [6:0] Y0    = 7'(CURSOR_Y0);

    state_t           state_q, state_d;
    logic [3:0][15:0] bar_q, bar_d;
    logic [3:0]       valid_q, valid_d;
    logic [7:0]       cx_q, cx_d;
    logic [6:0]       cy_q, cy_d;
    logic             cv_q, cv_d;
    logic [2:0]       slot_q, slot_d;
    logic [8:0]       nx, ny;

    // Candidates are 9 bits wide so a step below zero wraps high and fails the upper bound.
    function automatic logic x_ok(input logic [8:0] x, input logic v);
        return (x >= XLO) && (x <= (v ? XHI_V : XHI_H));
    endfunction

    function automatic logic y_ok(input logic [8:0] y, input logic v);
        return (y >= YLO) && (y <= (v ? YHI_V : YHI_H));
    endfunction

`ifdef BAR_OVERLAP_CHECK_EN
    localparam logic [9:0] LEN1 = 10'(BAR_LEN - 1);
    localparam logic [9:0] GAP  = 10'd2;

    logic place_err_q, place_err_d, reject;

    // Grow is applied to the far edge of the other box so nothing is ever subtracted.
    function automatic logic hit(input logic [15:0] b, input logic [7:0] x,
                                 input logic [6:0] y, input logic v);
        logic [9:0] ax0, ax1, ay0, ay1, bx0, bx1, by0, by1;
        ax0 = {2'b00, x};
        ay0 = {3'b000, y};
        ax1 = ax0 + (v ? 10'd0 : LEN1);
        ay1 = ay0 + (v ? LEN1 : 10'd0);
        bx0 = {2'b00, b[8:1]};
        by0 = {3'b000, b[15:9]};
        bx1 = bx0 + (b[0] ? 10'd0 : LEN1);
        by1 = by0 + (b[0] ? LEN1 : 10'd0);
        return (ax0 <= bx1 + GAP) && (bx0 <= ax1 + GAP) &&
               (ay0 <= by1 + GAP) && (by0 <= ay1 + GAP);
    endfunction

    always_comb begin
        reject = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (valid_q[i] && hit(bar_q[i], cx_q, cy_q, cv_q)) reject = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        bar_d   = bar_q;
        valid_d = valid_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        cv_d    = cv_q;
        slot_d  = slot_q;
        nx      = {1'b0, cx_q};
        ny      = {2'b00, cy_q};
`ifdef BAR_OVERLAP_CHECK_EN
        place_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EDIT;
                    cx_d    = X0;
                    cy_d    = Y0;
                    cv_d    = 1'b1;
                end
            end
            EDIT: begin
                if (btn_place) begin
`ifdef BAR_OVERLAP_CHECK_EN
                    if (reject) begin
                        place_err_d = 1'b1;
                    end else begin
`else
                    begin
`endif
                        bar_d[slot_q[1:0]]   = {cy_q, cx_q, cv_q};
                        valid_d[slot_q[1:0]] = 1'b1;
                        slot_d               = slot_q + 3'd1;
                        if (slot_q == 3'd3) state_d = LOCKED;
                    end
                end else if (btn_rotate) begin
                    cv_d = ~cv_q;
                    if (cv_q && ({1'b0, cx_q} > XHI_H)) cx_d = XHI_H[7:0];
                    if (!cv_q && ({2'b00, cy_q} > YHI_V)) cy_d = YHI_V[6:0];
                end else begin
                    if (btn_right && !btn_left) nx = {1'b0, cx_q} + STEP9;
                    if (btn_left && !btn_right) nx = {1'b0, cx_q} - STEP9;
                    if (btn_down && !btn_up)    ny = {2'b00, cy_q} + STEP9;
                    if (btn_up && !btn_down)    ny = {2'b00, cy_q} - STEP9;
                    if (x_ok(nx, cv_q)) cx_d = nx[7:0];
                    if (y_ok(ny, cv_q)) cy_d = ny[6:0];
                end
                if (btn_done) state_d = LOCKED;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bar_q   <= '0;
            valid_q <= '0;
            cx_q    <= X0;
            cy_q    <= Y0;
            cv_q    <= 1'b1;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            bar_q   <= bar_d;
            valid_q <= valid_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            cv_q    <= cv_d;
            slot_q  <= slot_d;
        end
    end

`ifdef BAR_OVERLAP_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) place_err_q <= 1'b0;
        else       place_err_q <= place_err_d;
    end
    assign place_err = place_err_q;
`else
    assign place_err = 1'b0;
`endif

    assign bar1        = bar_q[0];
    assign bar2        = bar_q[1];
    assign bar3        = bar_q[2];
    assign bar4        = bar_q[3];
    assign bar_valid   = valid_q;
    assign cursor_x    = cx_q;
    assign cursor_y    = cy_q;
    assign cursor_vert = cv_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_bar_placer.sv
// Self-checking bench for bar_placer: directed scenarios plus random pulses against a rule-level model.
module tb_bar_placer;

    localparam int L = 10, STEP = 1, X_MIN = 2, X_MAX = 112, Y_MIN = 4, Y_MAX = 115;
    localparam logic [8:0] B_RST = 9'h100, B_ST = 9'h080, B_L = 9'h040, B_R = 9'h020,
                           B_U = 9'h010, B_D = 9'h008, B_ROT = 9'h004, B_PL = 9'h002, B_DN = 9'h001;

    logic clk = 1'b0;
    logic reset = 1'b0, start = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0;
    logic btn_down = 1'b0, btn_rotate = 1'b0, btn_place = 1'b0, btn_done = 1'b0;
    logic [15:0] bar1, bar2, bar3, bar4;
    logic [3:0]  bar_valid;
    logic [7:0]  cursor_x;
    logic [6:0]  cursor_y;
    logic        cursor_vert, locked, place_err;
    logic [2:0]  slot;

    int compared = 0, mismatched = 0;

    // model state: mst 0 idle, 1 edit, 2 locked
    logic [15:0] mbar [4];
    logic [3:0]  mvalid;
    int          mx, my, mslot, mst;
    logic        mv, merr;

    bar_placer dut (
        .clk(clk), .reset(reset), .start(start), .btn_left(btn_left), .btn_right(btn_right),
        .btn_up(btn_up), .btn_down(btn_down), .btn_rotate(btn_rotate), .btn_place(btn_place),
        .btn_done(btn_done), .bar1(bar1), .bar2(bar2), .bar3(bar3), .bar4(bar4),
        .bar_valid(bar_valid), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_vert(cursor_vert), .slot(slot), .locked(locked), .place_err(place_err)
    );

    always #5 clk = ~clk;

    function automatic logic [88:0] dut_snap();
        return {bar1, bar2, bar3, bar4, bar_valid, cursor_x, cursor_y, cursor_vert,
                slot, locked, place_err};
    endfunction

    function automatic logic [88:0] model_snap();
        return {mbar[0], mbar[1], mbar[2], mbar[3], mvalid, 8'(mx), 7'(my), mv,
                3'(mslot), (mst == 2), merr};
    endfunction

    task automatic model_step(input logic [8:0] v);
        int nx, ny;
        logic ok;
`ifdef BAR_OVERLAP_CHECK_EN
        int bx, by;
        logic bv;
`endif
        merr = 1'b0;
        if (v[8]) begin
            for (int i = 0; i < 4; i++) mbar[i] = 16'h0000;
            mvalid = 4'b0; mx = 60; my = 60; mv = 1'b1; mslot = 0; mst = 0;
        end else if (mst == 0) begin
            if (v[7]) begin mst = 1; mx = 60; my = 60; mv = 1'b1; end
        end else if (mst == 1) begin
            if (v[1]) begin
                ok = 1'b1;
`ifdef BAR_OVERLAP_CHECK_EN
                for (int i = 0; i < 4; i++) begin
                    bx = int'(mbar[i][8:1]); by = int'(mbar[i][15:9]); bv = mbar[i][0];
                    if (mvalid[i] &&
                        mx - 2 <= bx + (bv ? 0 : L - 1) && bx <= mx + (mv ? 0 : L - 1) + 2 &&
                        my - 2 <= by + (bv ? L - 1 : 0) && by <= my + (mv ? L - 1 : 0) + 2)
                        ok = 1'b0;
                end
                if (!ok) merr = 1'b1;
`endif
                if (ok) begin
                    mbar[mslot] = {7'(my), 8'(mx), mv};
                    mvalid[mslot] = 1'b1;
                    mslot++;
                    if (mslot == 4) mst = 2;
                end
            end else if (v[2]) begin
                mv = ~mv;
                if (!mv && mx > X_MAX - L + 1) mx = X_MAX - L + 1;
                if (mv && my > Y_MAX - L + 1) my = Y_MAX - L + 1;
            end else begin
                nx = mx + (v[5] ? STEP : 0) - (v[6] ? STEP : 0);
                ny = my + (v[3] ? STEP : 0) - (v[4] ? STEP : 0);
                if (nx >= X_MIN && nx <= (mv ? X_MAX : X_MAX - L + 1)) mx = nx;
                if (ny >= Y_MIN && ny <= (mv ? Y_MAX - L + 1 : Y_MAX)) my = ny;
            end
            if (v[0]) mst = 2;
        end
    endtask

    task automatic drive(input logic [8:0] v);
        {reset, start, btn_left, btn_right, btn_up, btn_down, btn_rotate, btn_place, btn_done} = v;
        model_step(v);
        @(posedge clk);
        #1;
        {reset, start, btn_left, btn_right, btn_up, btn_down, btn_rotate, btn_place, btn_done} = '0;
    endtask

    task automatic drive_n(input logic [8:0] v, input int n);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    task automatic test_reset();
        drive(B_RST);
        compared++;
        if (dut_snap() !== model_snap()) begin
            mismatched++; $display("FAIL reset_snap: got %h want %h", dut_snap(), model_snap());
        end
        compared++;
        if ({bar1, bar_valid, cursor_x, cursor_y, cursor_vert, slot, locked} !==
            {16'h0000, 4'b0000, 8'd60, 7'd60, 1'b1, 3'd0, 1'b0}) begin
            mismatched++; $display("FAIL reset_values: got cursor %0d,%0d slot %0d locked %b",
                                   cursor_x, cursor_y, slot, locked);
        end
    endtask

    task automatic test_place_basic();
        drive(B_RST); drive(B_ST); drive_n(B_R, 3); drive(B_PL);
        compared++;
        if ({bar1, bar_valid, slot} !== {7'd60, 8'd63, 1'b1, 4'b0001, 3'd1}) begin
            mismatched++; $display("FAIL place_basic: got bar1 %h valid %b slot %0d want %h 0001 1",
                                   bar1, bar_valid, slot, {7'd60, 8'd63, 1'b1});
        end
        compared++;
        if (dut_snap() !== model_snap()) begin
            mismatched++; $display("FAIL place_basic_snap: got %h want %h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_boundary();
        drive(B_RST); drive(B_ST); drive(B_ROT); drive_n(B_R, 43);
        compared++;
        if (cursor_x !== 8'd103) begin
            mismatched++; $display("FAIL horiz_xmax: got %0d want 103", cursor_x);
        end
        drive(B_R);
        compared++;
        if (cursor_x !== 8'd103) begin
            mismatched++; $display("FAIL horiz_xmax_hold: got %0d want 103", cursor_x);
        end
        drive(B_ROT); drive_n(B_R, 12);
        compared++;
        if (cursor_x !== 8'd112) begin
            mismatched++; $display("FAIL vert_xmax: got %0d want 112", cursor_x);
        end
        drive(B_ROT);
        compared++;
        if ({cursor_x, cursor_vert} !== {8'd103, 1'b0}) begin
            mismatched++; $display("FAIL rotate_clamp_x: got %0d/%b want 103/0", cursor_x, cursor_vert);
        end
        drive_n(B_L, 120); drive_n(B_U, 70);
        compared++;
        if ({cursor_x, cursor_y} !== {8'd2, 7'd4}) begin
            mismatched++; $display("FAIL min_hold: got %0d,%0d want 2,4", cursor_x, cursor_y);
        end
        drive_n(B_D, 120); drive(B_ROT);
        compared++;
        if ({cursor_y, cursor_vert} !== {7'd106, 1'b1}) begin
            mismatched++; $display("FAIL rotate_clamp_y: got %0d/%b want 106/1", cursor_y, cursor_vert);
        end
        compared++;
        if (dut_snap() !== model_snap()) begin
            mismatched++; $display("FAIL boundary_snap: got %h want %h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_combo();
        drive(B_RST); drive(B_ST); drive(B_L | B_R | B_D);
        compared++;
        if ({cursor_x, cursor_y} !== {8'd60, 7'd61}) begin
            mismatched++; $display("FAIL combo_move: got %0d,%0d want 60,61", cursor_x, cursor_y);
        end
        drive(B_RST); drive(B_ST); drive(B_PL | B_U);
        compared++;
        if ({bar1[15:9], cursor_y, slot} !== {7'd60, 7'd60, 3'd1}) begin
            mismatched++; $display("FAIL place_over_move: got y %0d cursor_y %0d slot %0d want 60 60 1",
                                   bar1[15:9], cursor_y, slot);
        end
    endtask

    task automatic test_lock();
        drive(B_RST); drive(B_ST);
        for (int k = 0; k < 3; k++) begin drive(B_PL); drive_n(B_R, 5); end
        compared++;
        if ({locked, slot} !== {1'b0, 3'd3}) begin
            mismatched++; $display("FAIL pre_lock: got locked %b slot %0d want 0 3", locked, slot);
        end
        drive(B_PL);
        compared++;
        if ({locked, slot, bar_valid} !== {1'b1, 3'd4, 4'b1111}) begin
            mismatched++; $display("FAIL lock_on_4th: got locked %b slot %0d valid %b", locked, slot, bar_valid);
        end
        drive(B_PL); drive(B_L); drive(B_ST | B_ROT);
        compared++;
        if (dut_snap() !== model_snap() || bar4 !== {7'd60, 8'd75, 1'b1}) begin
            mismatched++; $display("FAIL lock_frozen: got %h want %h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_done();
        drive(B_RST); drive(B_ST); drive(B_DN);
        compared++;
        if ({locked, bar_valid, slot} !== {1'b1, 4'b0000, 3'd0}) begin
            mismatched++; $display("FAIL done_empty: got locked %b valid %b slot %0d", locked, bar_valid, slot);
        end
        drive(B_RST); drive(B_ST); drive(B_PL | B_DN);
        compared++;
        if ({locked, bar_valid} !== {1'b1, 4'b0001}) begin
            mismatched++; $display("FAIL place_done: got locked %b valid %b want 1 0001", locked, bar_valid);
        end
    endtask

    task automatic test_overlap();
        drive(B_RST); drive(B_ST); drive(B_PL); drive(B_R); drive(B_PL);
`ifdef BAR_OVERLAP_CHECK_EN
        compared++;
        if ({place_err, slot, bar2} !== {1'b1, 3'd1, 16'h0000}) begin
            mismatched++; $display("FAIL overlap_reject: got err %b slot %0d bar2 %h want 1 1 0000",
                                   place_err, slot, bar2);
        end
        drive(9'h000);
        compared++;
        if (place_err !== 1'b0) begin
            mismatched++; $display("FAIL overlap_err_pulse: got %b want 0", place_err);
        end
        drive(B_PL | B_DN);
        compared++;
        if ({locked, slot, place_err} !== {1'b1, 3'd1, 1'b1}) begin
            mismatched++; $display("FAIL overlap_done: got locked %b slot %0d err %b", locked, slot, place_err);
        end
`else
        compared++;
        if ({place_err, slot, bar2} !== {1'b0, 3'd2, 7'd60, 8'd61, 1'b1}) begin
            mismatched++; $display("FAIL no_overlap_check: got err %b slot %0d bar2 %h", place_err, slot, bar2);
        end
`endif
    endtask

    task automatic test_reset_mid();
        drive(B_RST); drive(B_ST); drive(B_PL); drive_n(B_R, 5); drive(B_PL); drive(B_D);
        drive(B_RST);
        compared++;
        if ({bar1, bar2, bar_valid, cursor_x, cursor_y, cursor_vert, slot, locked, place_err} !==
            {32'h0, 4'b0, 8'd60, 7'd60, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            mismatched++; $display("FAIL reset_mid: got %h", dut_snap());
        end
        drive(B_R | B_PL);
        compared++;
        if ({cursor_x, bar_valid} !== {8'd60, 4'b0}) begin
            mismatched++; $display("FAIL idle_ignores: got x %0d valid %b want 60 0000", cursor_x, bar_valid);
        end
    endtask

    task automatic test_random();
        logic [8:0] v;
        drive(B_RST);
        for (int n = 0; n < 1500; n++) begin
            v = '0;
            v[8] = ($urandom_range(0, 149) == 0);
            v[7] = ($urandom_range(0, 7) == 0);
            for (int b = 2; b <= 6; b++) v[b] = ($urandom_range(0, 3) == 0);
            v[1] = ($urandom_range(0, 9) == 0);
            v[0] = ($urandom_range(0, 79) == 0);
            drive(v);
            compared++;
            if (dut_snap() !== model_snap()) begin
                mismatched++;
                $display("FAIL random_%0d: got %h want %h", n, dut_snap(), model_snap());
            end
        end
    endtask

    initial begin
        test_reset();
        test_place_basic();
        test_boundary();
        test_combo();
        test_lock();
        test_done();
        test_overlap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
